// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants for the ARM execute stage: ALU command codes,
//               shifter type codes, status-register bit positions, operand
//               forwarding select codes and a signed-overflow helper.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    // ALU command codes carried by EXE_CMD
    localparam logic [3:0] c_EXE_MOV = 4'b0001;
    localparam logic [3:0] c_EXE_MVN = 4'b1001;
    localparam logic [3:0] c_EXE_ADD = 4'b0010;
    localparam logic [3:0] c_EXE_ADC = 4'b0011;
    localparam logic [3:0] c_EXE_SUB = 4'b0100;
    localparam logic [3:0] c_EXE_SBC = 4'b0101;
    localparam logic [3:0] c_EXE_AND = 4'b0110;
    localparam logic [3:0] c_EXE_ORR = 4'b0111;
    localparam logic [3:0] c_EXE_EOR = 4'b1000;

    // Register-operand shift types, taken from shifter operand bits [6:5]
    typedef enum logic [1:0] {
        c_SH_LSL = 2'b00,
        c_SH_LSR = 2'b01,
        c_SH_ASR = 2'b10,
        c_SH_ROR = 2'b11
    } shift_t;

    // Status register bit positions within {N,Z,C,V}
    localparam int c_SR_N = 3;
    localparam int c_SR_Z = 2;
    localparam int c_SR_C = 1;
    localparam int c_SR_V = 0;

    // Operand forwarding selects
    localparam logic [1:0] c_FWD_ID     = 2'b00;
    localparam logic [1:0] c_FWD_MEM    = 2'b01;
    localparam logic [1:0] c_FWD_WB     = 2'b10;
    localparam logic [1:0] c_FWD_ID_ALT = 2'b11;

    // Two's-complement overflow of a + b: operands agree in sign, result does not
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/val2_gen.sv
`default_nettype none
// ============================================================================
// Module      : val2_gen
// Description : Combinational builder of the second ALU operand (Val2).
//               Memory ops use the raw 12-bit offset, immediate form uses an
//               8-bit value rotated right by twice a 4-bit amount, register
//               form shifts Rm by a 5-bit amount with LSL/LSR/ASR/ROR.
// Revision    : 1.0 - initial release
// ============================================================================
module val2_gen
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
)
(
    input  logic [DATA_W-1:0] i_val_rm,
    input  logic [11:0]       i_shift_operand,
    input  logic              i_imm,
    input  logic              i_mem_op,
    output logic [DATA_W-1:0] o_val2
);

    logic [DATA_W-1:0] w_imm_base;
    logic [4:0]        w_imm_rot;
    logic [DATA_W-1:0] w_imm_val;
    logic [4:0]        w_sh_amt;
    shift_t            w_sh_type;
    logic [DATA_W-1:0] w_rm_ror;

    assign w_imm_base = {{(DATA_W-8){1'b0}}, i_shift_operand[7:0]};
    assign w_imm_rot  = {i_shift_operand[11:8], 1'b0};
    assign w_sh_amt   = i_shift_operand[11:7];
    assign w_sh_type  = shift_t'(i_shift_operand[6:5]);

    // A rotate amount of zero makes the left shift reach the full width,
    // which yields zero and leaves the value unrotated.
    assign w_imm_val = (w_imm_base >> w_imm_rot) | (w_imm_base << (DATA_W - int'(w_imm_rot)));
    assign w_rm_ror  = (i_val_rm >> w_sh_amt) | (i_val_rm << (DATA_W - int'(w_sh_amt)));

    // Select the operand form: memory offset, rotated immediate, or shifted register
    always_comb begin
        o_val2 = i_val_rm;
        if (i_mem_op) begin
            o_val2 = {{(DATA_W-12){1'b0}}, i_shift_operand};
        end else if (i_imm) begin
            o_val2 = w_imm_val;
        end else begin
            case (w_sh_type)
                c_SH_LSL: o_val2 = i_val_rm << w_sh_amt;
                c_SH_LSR: o_val2 = i_val_rm >> w_sh_amt;
                c_SH_ASR: o_val2 = $unsigned($signed(i_val_rm) >>> w_sh_amt);
                c_SH_ROR: o_val2 = w_rm_ror;
                default:  o_val2 = i_val_rm;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : Execute stage of the 5-stage ARM pipeline. Builds Val2, runs
//               the ALU, owns the {N,Z,C,V} status register, computes the
//               branch target and holds the EXE/MEM pipeline register.
//               Optional macro FORWARDING_EN adds operand forwarding ports.
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              WB_EN_IN,
    input  logic              MEM_R_EN_IN,
    input  logic              MEM_W_EN_IN,
    input  logic              B_IN,
    input  logic              S_IN,
    input  logic [3:0]        EXE_CMD_IN,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] Val_Rn_IN,
    input  logic [DATA_W-1:0] Val_Rm_IN,
    input  logic              imm_IN,
    input  logic [11:0]       Shift_operand_IN,
    input  logic [23:0]       Signed_imm_24_IN,
    input  logic [REG_AW-1:0] Dest_IN,
`ifdef FORWARDING_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] MEM_ALU_Res,
    input  logic [DATA_W-1:0] WB_Value,
`endif
    output logic              Branch_taken,
    output logic [DATA_W-1:0] Branch_Addr,
    output logic [3:0]        SR,
    output logic [DATA_W-1:0] ALU_Res,
    output logic [DATA_W-1:0] Val_Rm,
    output logic [REG_AW-1:0] Dest,
    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN
);

    logic [DATA_W-1:0] w_rn;
    logic [DATA_W-1:0] w_rm;
    logic [DATA_W-1:0] w_val2;
    logic [DATA_W-1:0] w_res;
    logic [DATA_W-1:0] w_add_b;
    logic [DATA_W:0]   w_sum;
    logic              w_carry_in;
    logic              w_arith;
    logic              w_cmd_known;
    logic [3:0]        w_sr_next;

    logic [3:0]        r_sr;
    logic [DATA_W-1:0] r_alu_res;
    logic [DATA_W-1:0] r_val_rm;
    logic [REG_AW-1:0] r_dest;
    logic              r_wb_en;
    logic              r_mem_r_en;
    logic              r_mem_w_en;

`ifdef FORWARDING_EN
    // Pick each operand from ID, the MEM-stage result, or the WB value
    always_comb begin
        w_rn = Val_Rn_IN;
        w_rm = Val_Rm_IN;
        case (sel_src1)
            c_FWD_MEM: w_rn = MEM_ALU_Res;
            c_FWD_WB:  w_rn = WB_Value;
            default:   w_rn = Val_Rn_IN;
        endcase
        case (sel_src2)
            c_FWD_MEM: w_rm = MEM_ALU_Res;
            c_FWD_WB:  w_rm = WB_Value;
            default:   w_rm = Val_Rm_IN;
        endcase
    end
`else
    assign w_rn = Val_Rn_IN;
    assign w_rm = Val_Rm_IN;
`endif

    val2_gen #(
        .DATA_W (DATA_W)
    ) u_val2_gen (
        .i_val_rm        (w_rm),
        .i_shift_operand (Shift_operand_IN),
        .i_imm           (imm_IN),
        .i_mem_op        (MEM_R_EN_IN | MEM_W_EN_IN),
        .o_val2          (w_val2)
    );

    // Branch target is word-scaled and resolved in the same cycle
    assign Branch_taken = B_IN;
    assign Branch_Addr  = PC_IN + {{(DATA_W-26){Signed_imm_24_IN[23]}}, Signed_imm_24_IN, 2'b00};

    // ALU: subtraction is a + ~b + carry-in, so the adder carry is NOT borrow
    always_comb begin
        w_res       = '0;
        w_sum       = '0;
        w_add_b     = w_val2;
        w_carry_in  = 1'b0;
        w_arith     = 1'b0;
        w_cmd_known = 1'b1;
        case (EXE_CMD_IN)
            c_EXE_MOV: w_res = w_val2;
            c_EXE_MVN: w_res = ~w_val2;
            c_EXE_ADD: w_arith = 1'b1;
            c_EXE_ADC: begin
                w_arith    = 1'b1;
                w_carry_in = r_sr[c_SR_C];
            end
            c_EXE_SUB: begin
                w_arith    = 1'b1;
                w_add_b    = ~w_val2;
                w_carry_in = 1'b1;
            end
            c_EXE_SBC: begin
                w_arith    = 1'b1;
                w_add_b    = ~w_val2;
                w_carry_in = r_sr[c_SR_C];
            end
            c_EXE_AND: w_res = w_rn & w_val2;
            c_EXE_ORR: w_res = w_rn | w_val2;
            c_EXE_EOR: w_res = w_rn ^ w_val2;
            default:   w_cmd_known = 1'b0;
        endcase
        if (w_arith) begin
            w_sum = {1'b0, w_rn} + {1'b0, w_add_b} + {{DATA_W{1'b0}}, w_carry_in};
            w_res = w_sum[DATA_W-1:0];
        end
    end

    // Next flags: N/Z always from the result, C/V only from arithmetic ops
    always_comb begin
        w_sr_next         = r_sr;
        w_sr_next[c_SR_N] = w_res[DATA_W-1];
        w_sr_next[c_SR_Z] = ~|w_res;
        if (w_arith) begin
            w_sr_next[c_SR_C] = w_sum[DATA_W];
            w_sr_next[c_SR_V] = add_overflow(w_rn[DATA_W-1], w_add_b[DATA_W-1], w_res[DATA_W-1]);
        end
    end

    // Status register: written by flag-setting, recognised commands unless stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else if (!freeze && S_IN && w_cmd_known) begin
            r_sr <= w_sr_next;
        end
    end

    // EXE/MEM pipeline register, held while the pipeline is frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_res  <= '0;
            r_val_rm   <= '0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
        end else if (!freeze) begin
            r_alu_res  <= w_res;
            r_val_rm   <= w_rm;
            r_dest     <= Dest_IN;
            r_wb_en    <= WB_EN_IN;
            r_mem_r_en <= MEM_R_EN_IN;
            r_mem_w_en <= MEM_W_EN_IN;
        end
    end

    assign SR       = r_sr;
    assign ALU_Res  = r_alu_res;
    assign Val_Rm   = r_val_rm;
    assign Dest     = r_dest;
    assign WB_EN    = r_wb_en;
    assign MEM_R_EN = r_mem_r_en;
    assign MEM_W_EN = r_mem_w_en;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Self-checking bench for exe_stage: directed vector table,
//               hand-written branch/freeze/reset sequences, and randomized
//               traffic against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, imm_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN, Val_Rn_IN, Val_Rm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;
    logic        Branch_taken;
    logic [31:0] Branch_Addr;
    logic [3:0]  SR;
    logic [31:0] ALU_Res, Val_Rm;
    logic [3:0]  Dest;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .WB_EN_IN         (WB_EN_IN),
        .MEM_R_EN_IN      (MEM_R_EN_IN),
        .MEM_W_EN_IN      (MEM_W_EN_IN),
        .B_IN             (B_IN),
        .S_IN             (S_IN),
        .EXE_CMD_IN       (EXE_CMD_IN),
        .PC_IN            (PC_IN),
        .Val_Rn_IN        (Val_Rn_IN),
        .Val_Rm_IN        (Val_Rm_IN),
        .imm_IN           (imm_IN),
        .Shift_operand_IN (Shift_operand_IN),
        .Signed_imm_24_IN (Signed_imm_24_IN),
        .Dest_IN          (Dest_IN),
        .Branch_taken     (Branch_taken),
        .Branch_Addr      (Branch_Addr),
        .SR               (SR),
        .ALU_Res          (ALU_Res),
        .Val_Rm           (Val_Rm),
        .Dest             (Dest),
        .WB_EN            (WB_EN),
        .MEM_R_EN         (MEM_R_EN),
        .MEM_W_EN         (MEM_W_EN)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Expected registered outputs
    logic [31:0] m_res, m_rm;
    logic [3:0]  m_sr, m_dest;
    logic        m_wb, m_mr, m_mw;

    typedef struct {
        logic [3:0]  cmd;
        bit          s, imm, mr, mw;
        logic [31:0] rn, rm;
        logic [11:0] op;
        logic [31:0] exp_res;
        logic [3:0]  exp_sr;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  sr;
    } mres_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [3:0] cmd, input bit s, input bit imm, input bit mr,
                                input bit mw, input logic [31:0] rn, input logic [31:0] rm,
                                input logic [11:0] op, input logic [31:0] er, input logic [3:0] es);
        vec_t v;
        v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw;
        v.rn = rn; v.rm = rm; v.op = op; v.exp_res = er; v.exp_sr = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, " res"},  ALU_Res, m_res);
        check({tag, " sr"},   32'(SR), 32'(m_sr));
        check({tag, " ctrl"}, 32'({Dest, WB_EN, MEM_R_EN, MEM_W_EN}), 32'({m_dest, m_wb, m_mr, m_mw}));
        check({tag, " rm"},   Val_Rm, m_rm);
    endtask

    task automatic drive(input logic [3:0] cmd, input bit s, input bit imm, input bit mr, input bit mw,
                         input logic [31:0] rn, input logic [31:0] rm, input logic [11:0] op,
                         input logic [3:0] dest);
        EXE_CMD_IN = cmd; S_IN = s; imm_IN = imm; MEM_R_EN_IN = mr; MEM_W_EN_IN = mw;
        Val_Rn_IN = rn; Val_Rm_IN = rm; Shift_operand_IN = op; Dest_IN = dest; WB_EN_IN = 1'b1;
    endtask

    // Reference Val2: rotations done one bit position at a time
    function automatic logic [31:0] m_val2(input logic [31:0] rm, input logic [11:0] op,
                                           input bit imm, input bit mem);
        logic [31:0] v;
        int amt;
        if (mem) return {20'd0, op};
        if (imm) begin
            v   = {24'd0, op[7:0]};
            amt = 2 * int'(op[11:8]);
            for (int k = 0; k < amt; k++) v = {v[0], v[31:1]};
            return v;
        end
        amt = int'(op[11:7]);
        case (op[6:5])
            2'b00:   return rm << amt;
            2'b01:   return rm >> amt;
            2'b10:   return $signed(rm) >>> amt;
            default: begin
                v = rm;
                for (int k = 0; k < amt; k++) v = {v[0], v[31:1]};
                return v;
            end
        endcase
    endfunction

    // Reference ALU on 64-bit integers: carry from unsigned range, overflow from signed range
    function automatic mres_t m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] sr, input bit s);
        mres_t o;
        longint unsigned ua, ub, cin;
        longint sa, sb, sv;
        bit arith, known;
        logic c, v;
        ua = a; ub = b; cin = sr[1];
        sa = longint'($signed(a)); sb = longint'($signed(b));
        c = sr[1]; v = sr[0]; sv = 0; arith = 0; known = 1;
        o.res = '0;
        case (cmd)
            4'd1: o.res = b;
            4'd9: o.res = ~b;
            4'd2: begin o.res = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; sv = sa + sb; arith = 1; end
            4'd3: begin
                o.res = 32'(ua + ub + cin); c = (ua + ub + cin) > 64'hFFFF_FFFF;
                sv = sa + sb + longint'(cin); arith = 1;
            end
            4'd4: begin o.res = 32'(ua - ub); c = ua >= ub; sv = sa - sb; arith = 1; end
            4'd5: begin
                o.res = 32'(ua - ub - (1 - cin)); c = ua >= ub + (1 - cin);
                sv = sa - sb - longint'(1 - cin); arith = 1;
            end
            4'd6: o.res = a & b;
            4'd7: o.res = a | b;
            4'd8: o.res = a ^ b;
            default: known = 0;
        endcase
        if (arith) v = (sv > 64'sh7FFF_FFFF) || (sv < -64'sh8000_0000);
        o.sr = (s && known) ? {o.res[31], o.res == 0, c, v} : sr;
        return o;
    endfunction

    initial begin
        mres_t r;
        logic [31:0] exp_addr;
        int off;

        tbl[0]  = mk(4'd2, 0, 1, 0, 0, 32'd5,          32'd0,          12'h00A, 32'h0000000F, 4'b0000);
        tbl[1]  = mk(4'd4, 1, 0, 0, 0, 32'd3,          32'd3,          12'h000, 32'h00000000, 4'b0110);
        tbl[2]  = mk(4'd2, 1, 1, 0, 0, 32'h7FFFFFFF,   32'd0,          12'h001, 32'h80000000, 4'b1001);
        tbl[3]  = mk(4'd1, 0, 1, 0, 0, 32'd0,          32'd0,          12'h2FF, 32'hF000000F, 4'b1001);
        tbl[4]  = mk(4'd1, 0, 0, 0, 0, 32'd0,          32'h80000000,   12'h0C4, 32'hC0000000, 4'b1001);
        tbl[5]  = mk(4'd2, 0, 0, 1, 0, 32'h100,        32'h12345678,   12'hFFF, 32'h000010FF, 4'b1001);
        tbl[6]  = mk(4'd3, 1, 0, 0, 0, 32'd1,          32'd1,          12'h000, 32'h00000002, 4'b0000);
        tbl[7]  = mk(4'd4, 1, 0, 0, 0, 32'd0,          32'd1,          12'h000, 32'hFFFFFFFF, 4'b1000);
        tbl[8]  = mk(4'd5, 1, 0, 0, 0, 32'd5,          32'd2,          12'h000, 32'h00000002, 4'b0010);
        tbl[9]  = mk(4'd3, 1, 0, 0, 0, 32'hFFFFFFFF,   32'd0,          12'h000, 32'h00000000, 4'b0110);
        tbl[10] = mk(4'd6, 1, 0, 0, 0, 32'h0000F0F0,   32'h00000FF0,   12'h000, 32'h000000F0, 4'b0010);
        tbl[11] = mk(4'd15, 1, 0, 0, 0, 32'h5,         32'h7,          12'h000, 32'h00000000, 4'b0010);
        tbl[12] = mk(4'd8, 1, 0, 0, 0, 32'h0000AAAA,   32'h0000AAAA,   12'h000, 32'h00000000, 4'b0110);
        tbl[13] = mk(4'd9, 1, 1, 0, 0, 32'd0,          32'd0,          12'h000, 32'hFFFFFFFF, 4'b1010);
        tbl[14] = mk(4'd7, 0, 0, 0, 0, 32'd1,          32'h80,         12'h220, 32'h00000009, 4'b1010);
        tbl[15] = mk(4'd1, 0, 0, 0, 0, 32'd0,          32'd1,          12'h0E0, 32'h80000000, 4'b1010);
        tbl[16] = mk(4'd2, 0, 1, 0, 1, 32'h1000,       32'hDEADBEEF,   12'h104, 32'h00001104, 4'b1010);

        // Reset state
        rst = 1'b0; freeze = 1'b0; B_IN = 1'b0; PC_IN = '0; Signed_imm_24_IN = '0;
        drive(4'd2, 1, 1, 0, 0, 32'hFFFF, 32'hFFFF, 12'h0FF, 4'hF);
        m_res = '0; m_rm = '0; m_sr = '0; m_dest = '0; m_wb = 0; m_mr = 0; m_mw = 0;
        @(posedge clk); @(posedge clk); #1;
        check_regs("reset");
        rst = 1'b1;

        // Directed vector table, applied back to back
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].cmd, tbl[i].s, tbl[i].imm, tbl[i].mr, tbl[i].mw,
                  tbl[i].rn, tbl[i].rm, tbl[i].op, 4'(i));
            @(posedge clk); #1;
            m_res = tbl[i].exp_res; m_sr = tbl[i].exp_sr; m_rm = tbl[i].rm;
            m_dest = 4'(i); m_wb = 1; m_mr = tbl[i].mr; m_mw = tbl[i].mw;
            check_regs($sformatf("vec%0d", i));
        end

        // Branch with a flag-setting compare in the same cycle
        drive(4'd4, 1, 0, 0, 0, 32'd3, 32'd3, 12'h000, 4'd2);
        B_IN = 1'b1; PC_IN = 32'h20; Signed_imm_24_IN = 24'hFFFFFE;
        #1;
        check("branch taken", 32'(Branch_taken), 32'd1);
        check("branch addr",  Branch_Addr, 32'h18);
        @(posedge clk); #1;
        m_res = 32'd0; m_sr = 4'b0110; m_rm = 32'd3; m_dest = 4'd2; m_wb = 1; m_mr = 0; m_mw = 0;
        check_regs("branch cmp");
        B_IN = 1'b0;

        // Freeze for two cycles with new inputs presented, then release
        freeze = 1'b1;
        drive(4'd2, 1, 1, 0, 0, 32'h7FFFFFFF, 32'h55, 12'h001, 4'd5);
        @(posedge clk); #1;
        check_regs("freeze1");
        Val_Rn_IN = 32'h7FFFFFFF;
        @(posedge clk); #1;
        check_regs("freeze2");
        freeze = 1'b0;
        @(posedge clk); #1;
        m_res = 32'h80000000; m_sr = 4'b1001; m_rm = 32'h55; m_dest = 4'd5;
        check_regs("unfreeze");

        // Randomized traffic against the reference model
        for (int it = 0; it < 400; it++) begin
            drive(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), $urandom, $urandom, 12'($urandom), 4'($urandom));
            WB_EN_IN = 1'($urandom);
            freeze   = ($urandom_range(0, 4) == 0);
            B_IN     = 1'($urandom);
            PC_IN    = $urandom & 32'hFFFF_FFFC;
            Signed_imm_24_IN = 24'($urandom);
            #1;
            off = int'(Signed_imm_24_IN);
            if (Signed_imm_24_IN >= 24'h800000) off = off - (1 << 24);
            exp_addr = PC_IN + 32'(off * 4);
            check("rand branch taken", 32'(Branch_taken), 32'(B_IN));
            check("rand branch addr", Branch_Addr, exp_addr);
            r = m_alu(EXE_CMD_IN, Val_Rn_IN,
                      m_val2(Val_Rm_IN, Shift_operand_IN, imm_IN, MEM_R_EN_IN | MEM_W_EN_IN),
                      m_sr, S_IN);
            @(posedge clk); #1;
            if (!freeze) begin
                m_res = r.res; m_sr = r.sr; m_rm = Val_Rm_IN; m_dest = Dest_IN;
                m_wb = WB_EN_IN; m_mr = MEM_R_EN_IN; m_mw = MEM_W_EN_IN;
            end
            check_regs("rand");
        end
        freeze = 1'b0; B_IN = 1'b0;

        // Asynchronous reset in the middle of a cycle with live results
        drive(4'd9, 1, 1, 0, 1, 32'd0, 32'hCAFE, 12'h000, 4'd9);
        @(posedge clk); #1;
        m_res = 32'hFFFFFFFF; m_sr = {1'b1, 1'b0, m_sr[1:0]}; m_rm = 32'hCAFE; m_dest = 4'd9;
        m_wb = 1; m_mr = 0; m_mw = 1;
        check_regs("pre reset");
        #2;
        rst = 1'b0;
        #1;
        m_res = '0; m_rm = '0; m_sr = '0; m_dest = '0; m_wb = 0; m_mr = 0; m_mw = 0;
        check_regs("async reset");
        @(posedge clk); #1;
        check_regs("held reset");
        rst = 1'b1;
        drive(4'd2, 0, 1, 0, 0, 32'd5, 32'd0, 12'h00A, 4'd1);
        @(posedge clk); #1;
        m_res = 32'hF; m_dest = 4'd1; m_wb = 1;
        check_regs("post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
